// File: rtl/cpu_bus_tracer.sv
// Bus-trace capture: timestamped circular buffer of cs cycles, frozen after an address trigger plus post-count.
// Optional idle-bus watchdog enabled by defining TRACE_WATCHDOG_EN.
module cpu_bus_tracer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic                                 cs,
  input  logic                                 wr_rd,
  input  logic [ADDR_W-1:0]                    ADDR,
  input  logic [DATA_W-1:0]                    Data_BUS_WRITE,
  input  logic [DATA_W-1:0]                    Data_BUS_READ,
  input  logic                                 arm,
  input  logic [ADDR_W-1:0]                    trig_addr,
  input  logic [ADDR_W-1:0]                    trig_mask,
  input  logic [$clog2(DEPTH)-1:0]             post_count,
  input  logic                                 rd_en,
  output logic [TS_W+1+ADDR_W+DATA_W-1:0]      rd_data,
  output logic                                 rd_valid,
  output logic [1:0]                           state,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 ovf,
  output logic                                 wdog
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TS_W + 1 + ADDR_W + DATA_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ARMED     = 2'd1;
  localparam logic [1:0] S_TRIGGERED = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (WDOG_CYCLES < 1)) begin : g_param_check
    $error("cpu_bus_tracer: DEPTH must be a power of 2 >= 4 and WDOG_CYCLES >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] post_q, post_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] entry;
  logic          mem_we;
  logic          hit;
  logic          full;

`ifdef TRACE_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wdog_q, wdog_d;
`endif

  assign entry = {ts_q, wr_rd, ADDR, (wr_rd ? Data_BUS_WRITE : Data_BUS_READ)};
  assign hit   = ((ADDR ^ trig_addr) & trig_mask) == '0;
  assign full  = count_q == CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    ovf_d      = ovf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
`ifdef TRACE_WATCHDOG_EN
    wd_cnt_d   = '0;
    wdog_d     = wdog_q;
`endif
    if (arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
      ovf_d    = 1'b0;
`ifdef TRACE_WATCHDOG_EN
      wdog_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_ARMED, S_TRIGGERED: begin
          if (cs) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            // A full buffer drops its oldest entry; after the trigger that is always a pre-trigger entry.
            if (full) begin
              rd_ptr_d = rd_ptr_q + PW'(1);
              if (state_q == S_ARMED) ovf_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (state_q == S_ARMED) begin
              if (hit) begin
                post_d  = post_count;
                state_d = (post_count == '0) ? S_DONE : S_TRIGGERED;
              end
            end else begin
              post_d = post_q - PW'(1);
              if (post_q == PW'(1)) state_d = S_DONE;
            end
          end else begin
`ifdef TRACE_WATCHDOG_EN
            wd_cnt_d = wd_cnt_q + WW'(1);
            if (wd_cnt_q == WW'(WDOG_CYCLES - 1)) begin
              state_d = S_DONE;
              wdog_d  = 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          if (rd_en && (count_q != '0)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
            count_d    = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array needs no reset: count and pointers gate every read.
  always_ff @(posedge CLK) begin
    if (reset && mem_we) mem_q[wr_ptr_q] <= entry;
  end

`ifdef TRACE_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      wdog_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wdog_q   <= wdog_d;
    end
  end
  assign wdog = wdog_q;
`else
  assign wdog = 1'b0;
`endif

  assign state    = state_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// Bench for cpu_bus_tracer: directed scenarios plus random traffic against a queue-based trace model.
module tb_cpu_bus_tracer;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int TS_W        = 8;
  localparam int WDOG_CYCLES = 8;
  localparam int PW          = $clog2(DEPTH);
  localparam int EW          = TS_W + 1 + ADDR_W + DATA_W;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              reset;
  logic              cs, wr_rd, arm, rd_en;
  logic [ADDR_W-1:0] ADDR, trig_addr, trig_mask;
  logic [DATA_W-1:0] Data_BUS_WRITE, Data_BUS_READ;
  logic [PW-1:0]     post_count;
  logic [EW-1:0]     rd_data;
  logic              rd_valid, ovf, wdog;
  logic [1:0]        state;
  logic [PW:0]       count;

  cpu_bus_tracer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .CLK(CLK), .reset(reset), .cs(cs), .wr_rd(wr_rd), .ADDR(ADDR),
    .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
    .arm(arm), .trig_addr(trig_addr), .trig_mask(trig_mask), .post_count(post_count),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
    .count(count), .ovf(ovf), .wdog(wdog)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the trace is a plain queue, oldest at the front
  int             m_state = 0;
  logic [EW-1:0]  m_trace[$];
  bit             m_ovf = 0, m_wdog = 0, m_rdv = 0;
  logic [TS_W-1:0] m_ts = '0;
  int             m_post = 0, m_wd = 0;
  logic [EW-1:0]  exp_q[$];

  always @(posedge CLK) begin
    logic [TS_W-1:0] cur_ts;
    if (!reset) begin
      m_state = 0; m_trace.delete(); m_ovf = 0; m_wdog = 0; m_rdv = 0;
      m_ts = '0; m_post = 0; m_wd = 0;
    end else begin
      cur_ts = m_ts;
      m_ts   = m_ts + 1'b1;
      m_rdv  = 0;
      if (arm) begin
        m_state = 1; m_trace.delete(); m_ovf = 0; m_wdog = 0; m_wd = 0;
      end else if (m_state == 1 || m_state == 2) begin
        if (cs) begin
          m_wd = 0;
          if (m_trace.size() == DEPTH) begin
            void'(m_trace.pop_front());
            if (m_state == 1) m_ovf = 1;
          end
          m_trace.push_back({cur_ts, wr_rd, ADDR, wr_rd ? Data_BUS_WRITE : Data_BUS_READ});
          if (m_state == 1) begin
            if (((ADDR ^ trig_addr) & trig_mask) == 0) begin
              m_post  = int'(post_count);
              m_state = (m_post == 0) ? 3 : 2;
            end
          end else begin
            m_post--;
            if (m_post == 0) m_state = 3;
          end
        end else begin
`ifdef TRACE_WATCHDOG_EN
          m_wd++;
          if (m_wd == WDOG_CYCLES) begin
            m_state = 3; m_wdog = 1;
          end
`endif
        end
      end else if (m_state == 3 && rd_en && m_trace.size() > 0) begin
        exp_q.push_back(m_trace.pop_front());
        m_rdv = 1;
      end
    end
  end

  // scoreboard monitor
  logic [EW-1:0] pop_log[$];
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    if (mon_en) begin
      check("status", {state, count, ovf, wdog, rd_valid},
            {2'(m_state), 3'(m_trace.size()), m_ovf, m_wdog, m_rdv});
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
        pop_log.push_back(rd_data);
      end
    end
  end

  // driver tasks
  task automatic drive(input bit rst_n, input bit c, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdd, input bit ar, input bit rd);
    @(negedge CLK);
    reset = rst_n; cs = c; wr_rd = w; ADDR = a;
    Data_BUS_WRITE = wd; Data_BUS_READ = rdd; arm = ar; rd_en = rd;
  endtask
  task automatic nop();            drive(1, 0, 0, $urandom, $urandom, $urandom, 0, 0); endtask
  task automatic do_arm();         drive(1, 1, 1, 32'h100, $urandom, $urandom, 1, 0); endtask
  task automatic wr(input logic [31:0] a); drive(1, 1, 1, a, $urandom, $urandom, 0, 0); endtask
  task automatic pop();            drive(1, 0, 0, $urandom, $urandom, $urandom, 0, 1); endtask

  function automatic logic [31:0] addr_of(input logic [EW-1:0] e);
    return e[DATA_W +: ADDR_W];
  endfunction

  initial begin
    logic [EW-1:0] e;
    int cs_pct;
    int r;
    reset = 0; cs = 1; wr_rd = 1; ADDR = 32'h100; arm = 0; rd_en = 0;
    Data_BUS_WRITE = 0; Data_BUS_READ = 0;
    trig_addr = 32'hFFFF0000; trig_mask = 32'hFFFFFFFF; post_count = 0;

    // reset with cs toggling
    @(negedge CLK); mon_en = 1; cs = 0;
    @(negedge CLK); cs = 1; rd_en = 1;
    @(negedge CLK);
    check("rst_state", state, 0); check("rst_count", count, 0); check("rst_ovf", ovf, 0);
    check("rst_rd_valid", rd_valid, 0); check("rst_wdog", wdog, 0); check("rst_rd_data", rd_data, 0);
    nop(); nop();
    check("idle_no_capture", count, 0);

    // overflow
    trig_addr = 32'hFFFF0000; trig_mask = 32'hFFFFFFFF; post_count = 0;
    do_arm();
    for (int i = 1; i <= 6; i++) wr(32'h10 * i);
    nop();
    check("ovf_count", count, 4); check("ovf_flag", ovf, 1); check("ovf_state", state, 1);
    pop(); nop();
    check("pop_in_armed", rd_valid, 0);

    // trigger window
    trig_addr = 32'h100; post_count = 2;
    do_arm();
    wr(32'h0F8); wr(32'h0FC); wr(32'h100); wr(32'h104); wr(32'h108); wr(32'h10C);
    nop();
    check("win_state", state, 3); check("win_count", count, 4);
    pop_log.delete();
    for (int i = 0; i < 5; i++) pop();
    nop();
    check("win_5th_pop", rd_valid, 0); check("win_empty", count, 0);
    nop();
    check("win_pops", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
      check("win_a0", addr_of(pop_log[0]), 32'h0FC); check("win_a1", addr_of(pop_log[1]), 32'h100);
      check("win_a2", addr_of(pop_log[2]), 32'h104); check("win_a3", addr_of(pop_log[3]), 32'h108);
    end

    // read capture
    trig_addr = 32'h20; trig_mask = 32'hFFFFFFF0; post_count = 0;
    do_arm();
    drive(1, 1, 0, 32'h24, 32'h12345678, 32'hDEADBEEF, 0, 0);
    nop();
    check("rdcap_state", state, 3);
    pop_log.delete();
    pop(); nop(); nop();
    check("rdcap_pops", pop_log.size(), 1);
    if (pop_log.size() == 1) begin
      e = pop_log[0];
      check("rdcap_wr", e[DATA_W + ADDR_W], 0);
      check("rdcap_addr", addr_of(e), 32'h24);
      check("rdcap_data", e[DATA_W-1:0], 32'hDEADBEEF);
    end

    // reset mid-capture
    trig_addr = 32'h100; trig_mask = 32'hFFFFFFFF; post_count = 3;
    do_arm();
    wr(32'h50); wr(32'h100); wr(32'h104);
    nop();
    check("mid_state", state, 2); check("mid_count", count, 3);
    drive(0, 1, 1, 32'h108, 0, 0, 0, 0);
    nop();
    check("mid_rst_state", state, 0); check("mid_rst_count", count, 0);
    pop(); nop();
    check("mid_rst_pop", rd_valid, 0);

    // watchdog
    trig_addr = 32'hFFFF0000; trig_mask = 32'hFFFFFFFF;
    do_arm();
    wr(32'h10); wr(32'h20);
`ifdef TRACE_WATCHDOG_EN
    for (int i = 0; i < WDOG_CYCLES + 1; i++) nop();
    check("wd_state", state, 3); check("wd_flag", wdog, 1); check("wd_count", count, 2);
    pop(); pop(); nop(); nop();
`else
    for (int i = 0; i < 100; i++) nop();
    check("wd_state", state, 1); check("wd_flag", wdog, 0); check("wd_count", count, 2);
`endif

    // random traffic
    for (int blk = 0; blk < 6; blk++) begin
      cs_pct = (blk % 2 == 0) ? 60 : 8;
      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(0, 999);
        if ($urandom_range(0, 39) == 0) begin
          trig_addr  = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
          case ($urandom_range(0, 2))
            0: trig_mask = 32'hFFFFFFFF;
            1: trig_mask = 32'hFFFFFF00;
            default: trig_mask = 32'h0;
          endcase
          post_count = PW'($urandom_range(0, DEPTH - 1));
        end
        drive(r >= 5,
              $urandom_range(0, 99) < cs_pct,
              $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 3)) * 4),
              $urandom, $urandom,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 2) == 0);
      end
    end

    nop(); nop(); nop();
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
